// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RISC control FSM (IF/ID/EX/MEM/WB)
//
// Sequences the datapath (PC, register file, ALU, data/stack memory, SP)
// through fetch, decode, execute, memory and write-back. All control outputs
// are combinational from the current state, the opcode and the ALU flags.
// Only the state register is clocked.
//
// Optional build macro: CU_ILLEGAL_TRAP_EN
//   When defined, the illegal_op output is added. An illegal opcode (>= 17)
//   then parks the FSM in ID with PCwrite=0 until reset.
//   When undefined, an illegal opcode runs as a 2-cycle NOP.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   OP                  6-bit opcode of the current instruction
//   Zeroflag, Negflag   ALU flags, meaningful in EX
//   state, next_state   current state and combinational next state
//   PCsrc, PCwrite      PC source select and PC load enable
//   IRwrite             instruction register load enable
//   ExtOp, Rs2Src       immediate extension and read-port-2 address select
//   RegRw, Rs1Rw        Rd write enable and Rs1 post-increment write enable
//   ALUsrc, ALUop       ALU B source and operation
//   DataInputSrc        memory write data select (register / PC+1)
//   MemR, MemW          memory read/write strobes, DataMemEn = MemR | MemW
//   WBdata              write-back source (ALU / memory)
//   illegal_op          (trap build only) illegal opcode seen in ID

module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zeroflag,
    input  logic       Negflag,
    output logic [2:0] state,
    output logic [2:0] next_state,
    output logic [1:0] PCsrc,
    output logic       PCwrite,
    output logic       IRwrite,
    output logic       ExtOp,
    output logic       Rs2Src,
    output logic       RegRw,
    output logic       Rs1Rw,
    output logic       ALUsrc,
    output logic       DataInputSrc,
    output logic [1:0] ALUop,
    output logic       MemR,
    output logic       MemW,
    output logic       WBdata,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       DataMemEn
);

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EX  = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [5:0] OP_AND  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ANDI = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_LWPI = 6'd6;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_BGT  = 6'd8;
    localparam logic [5:0] OP_BLT  = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_BNE  = 6'd11;
    localparam logic [5:0] OP_JMP  = 6'd12;
    localparam logic [5:0] OP_CALL = 6'd13;
    localparam logic [5:0] OP_RET  = 6'd14;
    localparam logic [5:0] OP_PUSH = 6'd15;
    localparam logic [5:0] OP_POP  = 6'd16;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch condition from the Rd - Rs1 comparison done by the ALU in EX.
    always_comb begin
        br_taken = 1'b0;
        case (OP)
            OP_BGT:  br_taken = !Zeroflag && !Negflag;
            OP_BLT:  br_taken = Negflag;
            OP_BEQ:  br_taken = Zeroflag;
            OP_BNE:  br_taken = !Zeroflag;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = S_IF;
        PCsrc        = 2'b00;
        PCwrite      = 1'b0;
        IRwrite      = 1'b0;
        ExtOp        = 1'b0;
        Rs2Src       = 1'b0;
        RegRw        = 1'b0;
        Rs1Rw        = 1'b0;
        ALUsrc       = 1'b0;
        DataInputSrc = 1'b0;
        ALUop        = 2'b00;
        MemR         = 1'b0;
        MemW         = 1'b0;
        WBdata       = 1'b0;
        case (state_q)
            S_IF: begin
                IRwrite = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (OP)
                    OP_JMP: begin
                        PCsrc   = 2'b10;
                        PCwrite = 1'b1;
                        state_d = S_IF;
                    end
                    OP_CALL, OP_RET, OP_PUSH, OP_POP: state_d = S_MEM;
                    OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI,
                    OP_LW, OP_LWPI, OP_SW,
                    OP_BGT, OP_BLT, OP_BEQ, OP_BNE:   state_d = S_EX;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        // Park here; only reset leaves this state.
                        state_d = S_ID;
`else
                        PCsrc   = 2'b00;
                        PCwrite = 1'b1;
                        state_d = S_IF;
`endif
                    end
                endcase
            end
            S_EX: begin
                ExtOp = (OP != OP_ANDI);
                case (OP)
                    OP_AND, OP_ANDI: ALUop = 2'b00;
                    OP_ADD, OP_ADDI, OP_LW, OP_LWPI, OP_SW: ALUop = 2'b01;
                    default: ALUop = 2'b10;
                endcase
                ALUsrc = (OP == OP_ANDI) || (OP == OP_ADDI) || (OP == OP_LW) ||
                         (OP == OP_LWPI) || (OP == OP_SW);
                Rs2Src = (OP == OP_SW) || (OP == OP_BGT) || (OP == OP_BLT) ||
                         (OP == OP_BEQ) || (OP == OP_BNE);
                case (OP)
                    OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_LWPI, OP_SW:                    state_d = S_MEM;
                    OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
                        PCwrite = 1'b1;
                        PCsrc   = br_taken ? 2'b01 : 2'b00;
                        state_d = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                case (OP)
                    OP_LW, OP_LWPI, OP_POP: begin
                        MemR    = 1'b1;
                        state_d = S_WB;
                    end
                    OP_RET: begin
                        MemR    = 1'b1;
                        PCsrc   = 2'b11;
                        PCwrite = 1'b1;
                        state_d = S_IF;
                    end
                    OP_SW, OP_PUSH: begin
                        MemW    = 1'b1;
                        PCsrc   = 2'b00;
                        PCwrite = 1'b1;
                        state_d = S_IF;
                    end
                    OP_CALL: begin
                        // Return address (PC+1) is pushed while jumping.
                        MemW         = 1'b1;
                        DataInputSrc = 1'b1;
                        PCsrc        = 2'b10;
                        PCwrite      = 1'b1;
                        state_d      = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_WB: begin
                RegRw   = 1'b1;
                PCsrc   = 2'b00;
                PCwrite = 1'b1;
                WBdata  = (OP == OP_LW) || (OP == OP_LWPI) || (OP == OP_POP);
                Rs1Rw   = (OP == OP_LWPI);
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_ID) && (OP > OP_POP);
`endif

    assign DataMemEn  = MemR | MemW;
    assign state      = state_q;
    assign next_state = state_d;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit

module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] OP;
    logic       Zeroflag;
    logic       Negflag;
    logic [2:0] state;
    logic [2:0] next_state;
    logic [1:0] PCsrc;
    logic       PCwrite;
    logic       IRwrite;
    logic       ExtOp;
    logic       Rs2Src;
    logic       RegRw;
    logic       Rs1Rw;
    logic       ALUsrc;
    logic       DataInputSrc;
    logic [1:0] ALUop;
    logic       MemR;
    logic       MemW;
    logic       WBdata;
    logic       DataMemEn;
`ifdef CU_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_checks;
    int n_fails;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .OP           (OP),
        .Zeroflag     (Zeroflag),
        .Negflag      (Negflag),
        .state        (state),
        .next_state   (next_state),
        .PCsrc        (PCsrc),
        .PCwrite      (PCwrite),
        .IRwrite      (IRwrite),
        .ExtOp        (ExtOp),
        .Rs2Src       (Rs2Src),
        .RegRw        (RegRw),
        .Rs1Rw        (Rs1Rw),
        .ALUsrc       (ALUsrc),
        .DataInputSrc (DataInputSrc),
        .ALUop        (ALUop),
        .MemR         (MemR),
        .MemW         (MemW),
        .WBdata       (WBdata),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal_op   (illegal_op),
`endif
        .DataMemEn    (DataMemEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 2 time units after the edge, away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        OP       = 6'd1;
        Zeroflag = 1'b0;
        Negflag  = 1'b0;

        // Reset state
        tick();
        check("rst_state",   32'(state),     32'd0);
        check("rst_irwrite", 32'(IRwrite),   32'd1);
        check("rst_pcwrite", 32'(PCwrite),   32'd0);
        check("rst_enables", 32'({RegRw, Rs1Rw, MemR, MemW, DataMemEn}), 32'd0);
        reset = 1'b0;
        tick();
        check("rel_id", 32'(state), 32'd1);

        // ADD: IF,ID,EX,WB,IF
        tick();
        check("add_ex_state",  32'(state),      32'd2);
        check("add_ex_aluop",  32'(ALUop),      32'd1);
        check("add_ex_alusrc", 32'(ALUsrc),     32'd0);
        check("add_ex_next",   32'(next_state), 32'd4);
        tick();
        check("add_wb_state",  32'(state),   32'd4);
        check("add_wb_regrw",  32'(RegRw),   32'd1);
        check("add_wb_wbdata", 32'(WBdata),  32'd0);
        check("add_wb_pcw",    32'(PCwrite), 32'd1);
        tick();
        check("add_if", 32'(state), 32'd0);

        // LW.POI: IF,ID,EX,MEM,WB
        OP = 6'd6;
        tick();
        check("lwpi_id", 32'(state), 32'd1);
        tick();
        check("lwpi_ex_alusrc", 32'(ALUsrc), 32'd1);
        check("lwpi_ex_next",   32'(next_state), 32'd3);
        tick();
        check("lwpi_mem_state", 32'(state), 32'd3);
        check("lwpi_mem_memr",  32'(MemR), 32'd1);
        check("lwpi_mem_dmen",  32'(DataMemEn), 32'd1);
        check("lwpi_mem_memw",  32'(MemW), 32'd0);
        tick();
        check("lwpi_wb_state", 32'(state),  32'd4);
        check("lwpi_wb_regrw", 32'(RegRw),  32'd1);
        check("lwpi_wb_rs1rw", 32'(Rs1Rw),  32'd1);
        check("lwpi_wb_wbdat", 32'(WBdata), 32'd1);
        tick();
        check("lwpi_if", 32'(state), 32'd0);

        // BEQ taken / not taken
        OP = 6'd10;
        tick();
        check("beq_id_next", 32'(next_state), 32'd2);
        tick();
        Zeroflag = 1'b1;
        #1;
        check("beq_t_pcsrc",  32'(PCsrc),      32'd1);
        check("beq_t_aluop",  32'(ALUop),      32'd2);
        check("beq_t_rs2src", 32'(Rs2Src),     32'd1);
        check("beq_t_pcw",    32'(PCwrite),    32'd1);
        check("beq_t_next",   32'(next_state), 32'd0);
        Zeroflag = 1'b0;
        #1;
        check("beq_nt_pcsrc", 32'(PCsrc), 32'd0);
        tick();
        check("beq_if", 32'(state), 32'd0);

        // BGT / BLT / BNE flag combinations in EX
        OP = 6'd8;
        tick();
        tick();
        check("bgt_ex_state", 32'(state), 32'd2);
        Zeroflag = 1'b0; Negflag = 1'b0; #1;
        check("bgt_t_pcsrc",  32'(PCsrc), 32'd1);
        Negflag = 1'b1; #1;
        check("bgt_nt_pcsrc", 32'(PCsrc), 32'd0);
        OP = 6'd9; #1;
        check("blt_t_pcsrc",  32'(PCsrc), 32'd1);
        Negflag = 1'b0; #1;
        check("blt_nt_pcsrc", 32'(PCsrc), 32'd0);
        OP = 6'd11; #1;
        check("bne_t_pcsrc",  32'(PCsrc), 32'd1);
        Zeroflag = 1'b1; #1;
        check("bne_nt_pcsrc", 32'(PCsrc), 32'd0);
        Zeroflag = 1'b0;
        tick();
        check("br_if", 32'(state), 32'd0);

        // ANDI decode in EX
        OP = 6'd3;
        tick();
        tick();
        check("andi_aluop",  32'(ALUop),      32'd0);
        check("andi_alusrc", 32'(ALUsrc),     32'd1);
        check("andi_extop",  32'(ExtOp),      32'd0);
        check("andi_next",   32'(next_state), 32'd4);
        tick();
        tick();
        check("andi_if", 32'(state), 32'd0);

        // SW: IF,ID,EX,MEM,IF
        OP = 6'd7;
        tick();
        tick();
        check("sw_ex_rs2src", 32'(Rs2Src),     32'd1);
        check("sw_ex_extop",  32'(ExtOp),      32'd1);
        check("sw_ex_next",   32'(next_state), 32'd3);
        tick();
        check("sw_mem_memw", 32'(MemW),       32'd1);
        check("sw_mem_pcw",  32'(PCwrite),    32'd1);
        check("sw_mem_next", 32'(next_state), 32'd0);
        tick();
        check("sw_if", 32'(state), 32'd0);

        // JMP
        OP = 6'd12;
        tick();
        check("jmp_pcsrc", 32'(PCsrc),      32'd2);
        check("jmp_pcw",   32'(PCwrite),    32'd1);
        check("jmp_next",  32'(next_state), 32'd0);
        tick();
        check("jmp_if", 32'(state), 32'd0);

        // CALL
        OP = 6'd13;
        tick();
        check("call_id_next", 32'(next_state), 32'd3);
        tick();
        check("call_mem_state", 32'(state),        32'd3);
        check("call_memw",      32'(MemW),         32'd1);
        check("call_dis",       32'(DataInputSrc), 32'd1);
        check("call_pcsrc",     32'(PCsrc),        32'd2);
        check("call_pcw",       32'(PCwrite),      32'd1);
        check("call_memr",      32'(MemR),         32'd0);
        tick();
        check("call_if", 32'(state), 32'd0);

        // RET
        OP = 6'd14;
        tick();
        tick();
        check("ret_memr",  32'(MemR),       32'd1);
        check("ret_pcsrc", 32'(PCsrc),      32'd3);
        check("ret_memw",  32'(MemW),       32'd0);
        check("ret_next",  32'(next_state), 32'd0);
        tick();
        check("ret_if", 32'(state), 32'd0);

        // Illegal opcode 20
        OP = 6'd20;
        tick();
        check("ill_id_state", 32'(state), 32'd1);
`ifdef CU_ILLEGAL_TRAP_EN
        check("ill_flag", 32'(illegal_op), 32'd1);
        check("ill_pcw",  32'(PCwrite),    32'd0);
        check("ill_next", 32'(next_state), 32'd1);
        tick();
        check("ill_hold", 32'(state), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ill_rst", 32'(state), 32'd0);
`else
        check("ill_pcw",   32'(PCwrite),    32'd1);
        check("ill_pcsrc", 32'(PCsrc),      32'd0);
        check("ill_next",  32'(next_state), 32'd0);
        tick();
        check("ill_if", 32'(state), 32'd0);
`endif

        // Reset mid-instruction returns to IF
        OP = 6'd1;
        tick();
        tick();
        check("mid_ex", 32'(state), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_if", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
